// File: rtl/mem_resp_pkg.sv
// Shared types and default parameters for the wait-state memory responder.
package mem_resp_pkg;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ADDR_W      = 12;
    localparam int DEF_DEPTH       = 1024;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with a registered read port that can be cleared or zero-loaded.
module mem_array
    import mem_resp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic              clr,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset so it maps onto RAM macros; only the output register resets.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (re) begin
            q <= clr ? '0 : mem[idx];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder: accepts one strobed access in IDLE, inserts wait states,
// pulses ready (and err for rejected accesses), then waits for the strobes to drop.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               wr_q, ill_q, oor_q;

    logic               req, req_ill, req_oor, req_wr;
    logic [IDX_W-1:0]   cur_idx;
    logic               cur_wr, cur_ill, cur_oor;
    logic               enter_resp, arr_re, arr_we;

    assign req     = MemRead | MemWrite;
    assign req_ill = MemRead & MemWrite;
    assign req_wr  = MemWrite & ~MemRead;
    assign req_oor = 32'(addr) >= 32'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment before the case keeps this purely combinational (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (cnt == '0) state_nxt = RESP;
            RESP: state_nxt = req ? HOLD : IDLE;
            HOLD: if (!req) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
            oor_q   <= 1'b0;
        end else if (state == IDLE && req) begin
            cnt     <= CNT_W'(WAIT_CYCLES);
            idx_q   <= addr[IDX_W-1:0];
            wdata_q <= wdata;
            wr_q    <= req_wr;
            ill_q   <= req_ill;
            oor_q   <= req_oor;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // With zero wait states RESP is entered at the accepting edge, so the live request drives the RAM.
    assign cur_idx = (state == IDLE) ? addr[IDX_W-1:0] : idx_q;
    assign cur_wr  = (state == IDLE) ? req_wr  : wr_q;
    assign cur_ill = (state == IDLE) ? req_ill : ill_q;
    assign cur_oor = (state == IDLE) ? req_oor : oor_q;

    assign enter_resp = (state_nxt == RESP) && (state != RESP);
    assign arr_re     = enter_resp & ~cur_wr & ~cur_ill;
    assign arr_we     = (state == RESP) & wr_q & ~ill_q & ~oor_q & ~rst;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .re    (arr_re),
        .clr   (cur_oor),
        .we    (arr_we),
        .idx   (cur_idx),
        .wdata (wdata_q),
        .q     (rdata)
    );

    always_comb begin
        ready = (state == RESP);
        err   = (state == RESP) & (ill_q | oor_q);
        busy  = (state != IDLE);
    end

endmodule
